// File: rtl/pong_pkg.sv
// Shared types and constants for the rally controller.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [3:0] SPEED_MAX = 4'd15;

    // Speed step that holds at SPEED_MAX instead of wrapping.
    function automatic logic [3:0] speed_inc(input logic [3:0] v);
        return (v == SPEED_MAX) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/lfsr5.sv
// Free-running 5-bit Fibonacci LFSR, polynomial x^5 + x^3 + 1.
// The seed is non-zero and the polynomial is primitive, so the
// register cycles through all 31 non-zero values and never hits zero.
module lfsr5 (
    input  logic       clk,
    input  logic       reset_n,
    output logic [4:0] q
);

    logic [4:0] lfsr_q;
    logic [4:0] lfsr_d;

    // Shift left, feeding back the XOR of the x^5 and x^3 taps.
    always_comb begin
        lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    end

    // Step every cycle; reset loads the non-zero seed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) lfsr_q <= 5'b00001;
        else          lfsr_q <= lfsr_d;
    end

    assign q = lfsr_q;

endmodule

// File: rtl/rally_ctrl.sv
// Rally controller: sequences serve, play, point scoring and game over.
// Optional feature: define PONG_SPEED_RAMP_EN to ramp ball speed with
// paddle hits; without it speed stays at SPEED_INIT during a game.
//
// state    | meaning
// IDLE     | after reset, waiting for a start press
// SERVE    | ball held at centre for SERVE_DELAY cycles
// PLAY     | ball live; outs score, hits may ramp speed
// POINT    | one cycle after a score; reload speed, check for a winner
// GAMEOVER | a player reached WIN_SCORE; waiting for a start press
module rally_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_DELAY   = 2000,
    parameter int WIN_SCORE     = 9,
    parameter int SPEED_INIT    = 4,
    parameter int HITS_PER_STEP = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       paddle_hit,
    input  logic       out_left,
    input  logic       out_right,
    output logic       ball_reset,
    output logic [3:0] speed,
    output logic [4:0] entropy,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over
);

    localparam logic [11:0] SERVE_LOAD = 12'(SERVE_DELAY - 1);
    localparam logic [3:0]  WIN        = 4'(WIN_SCORE);
    localparam logic [3:0]  SPD_INIT   = 4'(SPEED_INIT);

    state_t      state_q, state_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic [3:0]  speed_q, speed_d;
    logic [11:0] serve_cnt_q, serve_cnt_d;
    logic        start_q;
    logic        ball_reset_q, ball_reset_d;
    logic        game_over_q, game_over_d;
    logic        start_rise;

`ifdef PONG_SPEED_RAMP_EN
    localparam logic [3:0] HIT_LAST = 4'(HITS_PER_STEP - 1);
    logic [3:0] hit_cnt_q, hit_cnt_d;
`else
    logic unused_hit;
    assign unused_hit = paddle_hit;
`endif

    assign start_rise = start & ~start_q;

    lfsr5 u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (entropy)
    );

    // Next-state and next-output computation for the rally sequence.
    always_comb begin
        state_d     = state_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        speed_d     = speed_q;
        serve_cnt_d = serve_cnt_q;
`ifdef PONG_SPEED_RAMP_EN
        hit_cnt_d   = hit_cnt_q;
`endif
        case (state_q)
            IDLE, GAMEOVER: begin
                if (start_rise) begin
                    score_l_d   = 4'd0;
                    score_r_d   = 4'd0;
                    speed_d     = SPD_INIT;
                    serve_cnt_d = SERVE_LOAD;
`ifdef PONG_SPEED_RAMP_EN
                    hit_cnt_d   = 4'd0;
`endif
                    state_d     = SERVE;
                end
            end
            SERVE: begin
                if (serve_cnt_q == 12'd0) state_d = PLAY;
                else                      serve_cnt_d = serve_cnt_q - 12'd1;
            end
            PLAY: begin
                // out_left wins a double out; any out masks a paddle hit.
                if (out_left) begin
                    score_r_d = score_r_q + 4'd1;
                    state_d   = POINT;
                end else if (out_right) begin
                    score_l_d = score_l_q + 4'd1;
                    state_d   = POINT;
                end
`ifdef PONG_SPEED_RAMP_EN
                else if (paddle_hit) begin
                    if (hit_cnt_q == HIT_LAST) begin
                        hit_cnt_d = 4'd0;
                        speed_d   = speed_inc(speed_q);
                    end else begin
                        hit_cnt_d = hit_cnt_q + 4'd1;
                    end
                end
`endif
            end
            POINT: begin
                speed_d = SPD_INIT;
`ifdef PONG_SPEED_RAMP_EN
                hit_cnt_d = 4'd0;
`endif
                if (score_l_q == WIN || score_r_q == WIN) begin
                    state_d = GAMEOVER;
                    speed_d = 4'd0;
                end else begin
                    state_d     = SERVE;
                    serve_cnt_d = SERVE_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                speed_d = 4'd0;
            end
        endcase
        ball_reset_d = (state_d != PLAY);
        game_over_d  = (state_d == GAMEOVER);
    end

    // Register state, counters and outputs; reset aborts to IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
            speed_q      <= 4'd0;
            serve_cnt_q  <= 12'd0;
            start_q      <= 1'b0;
            ball_reset_q <= 1'b1;
            game_over_q  <= 1'b0;
`ifdef PONG_SPEED_RAMP_EN
            hit_cnt_q    <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            score_l_q    <= score_l_d;
            score_r_q    <= score_r_d;
            speed_q      <= speed_d;
            serve_cnt_q  <= serve_cnt_d;
            start_q      <= start;
            ball_reset_q <= ball_reset_d;
            game_over_q  <= game_over_d;
`ifdef PONG_SPEED_RAMP_EN
            hit_cnt_q    <= hit_cnt_d;
`endif
        end
    end

    assign ball_reset = ball_reset_q;
    assign speed      = speed_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Testbench for rally_ctrl: randomized and directed stimulus with a
// behavioural game model feeding an expected-output queue.
module tb_rally_ctrl;

    localparam int SERVE_DELAY   = 2000;
    localparam int WIN_SCORE     = 9;
    localparam int SPEED_INIT    = 4;
    localparam int HITS_PER_STEP = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       paddle_hit = 1'b0;
    logic       out_left = 1'b0;
    logic       out_right = 1'b0;
    logic       ball_reset;
    logic [3:0] speed;
    logic [4:0] entropy;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;

    always #5 clk = ~clk;

    rally_ctrl #(
        .SERVE_DELAY   (SERVE_DELAY),
        .WIN_SCORE     (WIN_SCORE),
        .SPEED_INIT    (SPEED_INIT),
        .HITS_PER_STEP (HITS_PER_STEP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .paddle_hit (paddle_hit),
        .out_left   (out_left),
        .out_right  (out_right),
        .ball_reset (ball_reset),
        .speed      (speed),
        .entropy    (entropy),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over)
    );

    typedef struct packed {
        logic       br;
        logic [3:0] spd;
        logic [3:0] sl;
        logic [3:0] sr;
        logic       go;
        logic [4:0] ent;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Game model: mode, scores, live speed, hits since last speed-up,
    // serve cycles remaining, last start level, expected LFSR value.
    typedef enum int {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER} mode_t;
    mode_t      m_mode = M_IDLE;
    int         m_sl = 0, m_sr = 0, m_spd = 0, m_hits = 0, m_wait = 0;
    bit         m_prev = 0;
    logic [4:0] m_lfsr = 5'd1;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic void new_game();
        m_sl = 0; m_sr = 0; m_spd = SPEED_INIT; m_hits = 0;
        m_wait = SERVE_DELAY; m_mode = M_SERVE;
    endfunction

    function automatic void model_step(bit rst, bit st, bit hit, bit ol, bit orr);
        bit rise;
        if (!rst) begin
            m_mode = M_IDLE; m_sl = 0; m_sr = 0; m_spd = 0; m_hits = 0;
            m_wait = 0; m_prev = 0; m_lfsr = 5'd1;
            return;
        end
        rise   = st && !m_prev;
        m_prev = st;
        m_lfsr = {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
        case (m_mode)
            M_IDLE, M_OVER: if (rise) new_game();
            M_SERVE: begin
                m_wait--;
                if (m_wait == 0) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (ol) begin
                    m_sr++; m_mode = M_POINT;
                end else if (orr) begin
                    m_sl++; m_mode = M_POINT;
                end else if (hit) begin
`ifdef PONG_SPEED_RAMP_EN
                    m_hits++;
                    if (m_hits == HITS_PER_STEP) begin
                        m_hits = 0;
                        if (m_spd < 15) m_spd++;
                    end
`endif
                end
            end
            M_POINT: begin
                m_spd = SPEED_INIT; m_hits = 0;
                if (m_sl == WIN_SCORE || m_sr == WIN_SCORE) m_mode = M_OVER;
                else begin
                    m_mode = M_SERVE; m_wait = SERVE_DELAY;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the
    // outputs after the next rising edge and queue them.
    task automatic cycle(input bit rst, input bit st, input bit hit, input bit ol, input bit orr);
        exp_t e;
        @(negedge clk);
        reset_n    = rst;
        start      = st;
        paddle_hit = hit;
        out_left   = ol;
        out_right  = orr;
        model_step(rst, st, hit, ol, orr);
        e.br  = (m_mode != M_PLAY);
        e.spd = (m_mode == M_IDLE || m_mode == M_OVER) ? 4'd0 : 4'(m_spd);
        e.sl  = 4'(m_sl);
        e.sr  = 4'(m_sr);
        e.go  = (m_mode == M_OVER);
        e.ent = m_lfsr;
        exp_q.push_back(e);
    endtask

    task automatic wait_mode(input mode_t target, input int budget, input bit st);
        for (int i = 0; i < budget && m_mode != target; i++) cycle(1, st, 0, 0, 0);
        if (m_mode != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_mode: did not reach mode %0d within %0d cycles", target, budget);
        end
    endtask

    // Monitor: after each rising edge, compare DUT outputs with the
    // oldest queued prediction; entropy must also never be zero.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ball_reset", int'(ball_reset), int'(e.br));
                check("speed",      int'(speed),      int'(e.spd));
                check("score_l",    int'(score_l),    int'(e.sl));
                check("score_r",    int'(score_r),    int'(e.sr));
                check("game_over",  int'(game_over),  int'(e.go));
                check("entropy",    int'(entropy),    int'(e.ent));
                n_cmp++;
                if (entropy == 5'd0) begin
                    n_bad++;
                    $display("FAIL entropy_nonzero: got 0, required non-zero at %0t", $time);
                end
            end
        end
    end

    initial begin
        bit ol, orr;
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Start press held high: serve must not retrigger.
        cycle(1, 1, 0, 0, 0);
        repeat (20) cycle(1, 1, 0, 0, 0);
        wait_mode(M_PLAY, SERVE_DELAY + 50, 0);

        // Speed ramp: 4 hits, then 48 more to saturate.
        repeat (4) begin
            cycle(1, 0, 1, 0, 0);
            cycle(1, 0, 0, 0, 0);
        end
        repeat (48) begin
            cycle(1, 0, 1, 0, 0);
            cycle(1, 0, 0, 0, 0);
        end

        // Left player scores; point cycle then serve with speed reloaded.
        cycle(1, 0, 0, 0, 1);
        repeat (3) cycle(1, 0, 0, 0, 0);
        wait_mode(M_PLAY, SERVE_DELAY + 50, 0);

        // Both outs plus a hit: only right player scores.
        cycle(1, 0, 1, 1, 1);
        wait_mode(M_PLAY, SERVE_DELAY + 50, 0);

        // Randomized play, including inputs outside PLAY, until match point.
        for (int i = 0; i < 20000; i++) begin
            if (m_sl >= WIN_SCORE - 1 || m_sr >= WIN_SCORE - 1) break;
            cycle(1, $urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0);
        end

        // Finish the game by out in PLAY while start is held high.
        for (int i = 0; i < 2 * WIN_SCORE && m_mode != M_OVER; i++) begin
            wait_mode(M_PLAY, SERVE_DELAY + 50, 1);
            ol  = (m_sl < m_sr);
            orr = !ol;
            cycle(1, 1, 0, ol, orr);
            cycle(1, 1, 0, 0, 0);
        end
        repeat (10) cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Mid-PLAY reset must act immediately.
        wait_mode(M_PLAY, SERVE_DELAY + 50, 0);
        repeat (6) cycle(1, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #1;
        check("async_rst_ball_reset", int'(ball_reset), 1);
        check("async_rst_speed",      int'(speed),      0);
        check("async_rst_score_l",    int'(score_l),    0);
        check("async_rst_score_r",    int'(score_r),    0);
        check("async_rst_game_over",  int'(game_over),  0);
        check("async_rst_entropy",    int'(entropy),    1);
        cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Idle with noise on the play inputs; entropy keeps running.
        for (int i = 0; i < 10000; i++)
            cycle(1, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));

        @(posedge clk);
        #2;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
